// File: rtl/parking_pkg.sv
// Shared definitions for the parking zone controller: class indices,
// default capacities and a helper that extracts one class capacity from
// the flattened capacity vector.
package parking_pkg;

  localparam int CLASS_UNI      = 0;
  localparam int CLASS_PUBLIC   = 1;

  localparam int UNI_CAP        = 500;
  localparam int PUBLIC_CAP     = 200;
  localparam int SHARED_CAP_DEF = 16;

  // Widest flattened capacity vector the helper can slice
  localparam int CAP_VEC_W      = 512;

  // Returns the capacity of class idx from a vector of width-bit slices
  function automatic logic [31:0] cap_of(input logic [CAP_VEC_W-1:0] caps,
                                         input int idx,
                                         input int width);
    logic [CAP_VEC_W-1:0] shifted;
    logic [31:0]          result;
    shifted = caps >> (idx * width);
    result  = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < width) result[b] = shifted[b];
    end
    return result;
  endfunction

endpackage

// File: rtl/parking_class_counter.sv
// Occupancy bookkeeping for one vehicle class: private spaces used and
// spaces borrowed from the shared overflow pool. The top level guarantees
// every strobe is legal, so the counters never need saturation.
module parking_class_counter #(
  parameter int              CNT_W = 10,
  parameter logic [CNT_W-1:0] CAP  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_inc_private,
  input  logic             i_dec_private,
  input  logic             i_inc_borrow,
  input  logic             i_dec_borrow,
  output logic [CNT_W-1:0] o_private,
  output logic [CNT_W-1:0] o_borrowed,
  output logic             o_full,
  output logic             o_has_private,
  output logic             o_has_borrow
);

  logic [CNT_W-1:0] r_private;
  logic [CNT_W-1:0] r_borrowed;

  // Increment and decrement may coincide when an exit and an entry of the
  // same class land in one cycle; the net change is then zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_private  <= '0;
      r_borrowed <= '0;
    end else begin
      r_private  <= r_private  + CNT_W'(i_inc_private) - CNT_W'(i_dec_private);
      r_borrowed <= r_borrowed + CNT_W'(i_inc_borrow)  - CNT_W'(i_dec_borrow);
    end
  end

  assign o_private     = r_private;
  assign o_borrowed    = r_borrowed;
  assign o_full        = (r_private >= CAP);
  assign o_has_private = (r_private != '0);
  assign o_has_borrow  = (r_borrowed != '0);

endmodule

// File: rtl/parking_zone_controller.sv
// Multi-class parking controller. Each class owns a private block of
// spaces and may borrow from a shared overflow pool once its block is full.
// Gate requests are edge-detected; every event yields a one-cycle ack or
// nack. Exits are resolved before entries so an entry sees the freed space.
module parking_zone_controller
  import parking_pkg::*;
#(
  parameter int NUM_CLASS  = 2,
  parameter int CNT_W      = 10,
  parameter int CLS_W      = 1,
  parameter logic [NUM_CLASS*CNT_W-1:0] CLASS_CAP =
    {CNT_W'(PUBLIC_CAP), CNT_W'(UNI_CAP)},
  parameter int SHARED_CAP = SHARED_CAP_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       entry_req,
  input  logic [CLS_W-1:0]           entry_class,
  input  logic                       exit_req,
  input  logic [CLS_W-1:0]           exit_class,
  output logic                       entry_ack,
  output logic                       entry_nack,
  output logic                       exit_ack,
  output logic                       exit_nack,
  output logic [NUM_CLASS*CNT_W-1:0] parked_cnt,
  output logic [NUM_CLASS*CNT_W-1:0] free_cnt,
  output logic [CNT_W-1:0]           shared_used,
  output logic [NUM_CLASS-1:0]       space_avail
);

  logic             r_entry_q;
  logic             r_exit_q;
  logic [CNT_W-1:0] r_shared;
  logic             r_entry_ack;
  logic             r_entry_nack;
  logic             r_exit_ack;
  logic             r_exit_nack;

  logic                 w_entry_evt;
  logic                 w_exit_evt;
  logic [NUM_CLASS-1:0] w_entry_sel;
  logic [NUM_CLASS-1:0] w_exit_sel;
  logic [NUM_CLASS-1:0] w_full;
  logic [NUM_CLASS-1:0] w_full_post;
  logic [NUM_CLASS-1:0] w_has_private;
  logic [NUM_CLASS-1:0] w_has_borrow;
  logic [NUM_CLASS-1:0] w_inc_private;
  logic [NUM_CLASS-1:0] w_inc_borrow;
  logic [NUM_CLASS-1:0] w_dec_private;
  logic [NUM_CLASS-1:0] w_dec_borrow;
  logic [CNT_W-1:0]     w_private  [NUM_CLASS];
  logic [CNT_W-1:0]     w_borrowed [NUM_CLASS];
  logic [CNT_W-1:0]     w_shared_post;
  logic                 w_shared_room_post;
  logic                 w_shared_room_now;
  logic                 w_entry_ok;
  logic                 w_exit_ok;

  assign w_entry_evt = entry_req & ~r_entry_q;
  assign w_exit_evt  = exit_req  & ~r_exit_q;

  // Pool state as the entry sees it, after any borrowed space the exit frees
  assign w_shared_post      = r_shared - CNT_W'(|w_dec_borrow);
  assign w_shared_room_post = (int'(w_shared_post) < SHARED_CAP);
  assign w_shared_room_now  = (int'(r_shared) < SHARED_CAP);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CLASS; gi++) begin : g_class
      localparam logic [CNT_W-1:0] CAP_I =
        CNT_W'(cap_of(CAP_VEC_W'(CLASS_CAP), gi, CNT_W));

      logic [CNT_W-1:0] w_free;

      // An out-of-range class index selects no class and ends up nacked
      assign w_entry_sel[gi] = w_entry_evt && (entry_class == CLS_W'(gi));
      assign w_exit_sel[gi]  = w_exit_evt  && (exit_class  == CLS_W'(gi));

      // Exit releases borrowed spaces before private ones
      assign w_dec_borrow[gi]  = w_exit_sel[gi] & w_has_borrow[gi];
      assign w_dec_private[gi] = w_exit_sel[gi] & ~w_has_borrow[gi] & w_has_private[gi];

      // Entry prefers a private space, then borrows from the pool
      assign w_full_post[gi]   = w_full[gi] & ~w_dec_private[gi];
      assign w_inc_private[gi] = w_entry_sel[gi] & ~w_full_post[gi];
      assign w_inc_borrow[gi]  = w_entry_sel[gi] & w_full_post[gi] & w_shared_room_post;

      parking_class_counter #(
        .CNT_W (CNT_W),
        .CAP   (CAP_I)
      ) u_counter (
        .clk           (clk),
        .reset         (reset),
        .i_inc_private (w_inc_private[gi]),
        .i_dec_private (w_dec_private[gi]),
        .i_inc_borrow  (w_inc_borrow[gi]),
        .i_dec_borrow  (w_dec_borrow[gi]),
        .o_private     (w_private[gi]),
        .o_borrowed    (w_borrowed[gi]),
        .o_full        (w_full[gi]),
        .o_has_private (w_has_private[gi]),
        .o_has_borrow  (w_has_borrow[gi])
      );

      assign w_free                         = CAP_I - w_private[gi];
      assign free_cnt[gi*CNT_W +: CNT_W]    = w_free;
      assign parked_cnt[gi*CNT_W +: CNT_W]  = w_private[gi] + w_borrowed[gi];
      assign space_avail[gi]                = (w_free != '0) || w_shared_room_now;
    end
  endgenerate

  assign w_entry_ok = |(w_inc_private | w_inc_borrow);
  assign w_exit_ok  = |(w_dec_private | w_dec_borrow);

  // Request history, shared pool occupancy and the one-cycle response pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_entry_q    <= 1'b1;
      r_exit_q     <= 1'b1;
      r_shared     <= '0;
      r_entry_ack  <= 1'b0;
      r_entry_nack <= 1'b0;
      r_exit_ack   <= 1'b0;
      r_exit_nack  <= 1'b0;
    end else begin
      r_entry_q    <= entry_req;
      r_exit_q     <= exit_req;
      r_shared     <= r_shared + CNT_W'(|w_inc_borrow) - CNT_W'(|w_dec_borrow);
      r_entry_ack  <= w_entry_evt &  w_entry_ok;
      r_entry_nack <= w_entry_evt & ~w_entry_ok;
      r_exit_ack   <= w_exit_evt  &  w_exit_ok;
      r_exit_nack  <= w_exit_evt  & ~w_exit_ok;
    end
  end

  assign entry_ack   = r_entry_ack;
  assign entry_nack  = r_entry_nack;
  assign exit_ack    = r_exit_ack;
  assign exit_nack   = r_exit_nack;
  assign shared_used = r_shared;

endmodule

// File: tb/tb_parking_zone_controller.sv
// Directed bench for parking_zone_controller with two classes, a 2-bit
// class index (so indices 2 and 3 are invalid), capacities 500/200 and a
// 16-space shared pool.
module tb_parking_zone_controller;
  import parking_pkg::*;

  localparam int NC = 2;
  localparam int CW = 10;
  localparam int LW = 2;

  logic            clk;
  logic            reset;
  logic            entry_req;
  logic [LW-1:0]   entry_class;
  logic            exit_req;
  logic [LW-1:0]   exit_class;
  logic            entry_ack;
  logic            entry_nack;
  logic            exit_ack;
  logic            exit_nack;
  logic [NC*CW-1:0] parked_cnt;
  logic [NC*CW-1:0] free_cnt;
  logic [CW-1:0]   shared_used;
  logic [NC-1:0]   space_avail;

  int checkCount;
  int failCount;
  int ackCount;

  parking_zone_controller #(
    .NUM_CLASS  (NC),
    .CNT_W      (CW),
    .CLS_W      (LW),
    .CLASS_CAP  ({10'd200, 10'd500}),
    .SHARED_CAP (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .entry_req   (entry_req),
    .entry_class (entry_class),
    .exit_req    (exit_req),
    .exit_class  (exit_class),
    .entry_ack   (entry_ack),
    .entry_nack  (entry_nack),
    .exit_ack    (exit_ack),
    .exit_nack   (exit_nack),
    .parked_cnt  (parked_cnt),
    .free_cnt    (free_cnt),
    .shared_used (shared_used),
    .space_avail (space_avail)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Counts one comparison and reports it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // One rising edge on the selected gates; returns on the negedge where the
  // response pulse is visible, with the requests already dropped
  task automatic applyStimulus(input logic doEntry, input logic [LW-1:0] eCls,
                               input logic doExit, input logic [LW-1:0] xCls);
    @(negedge clk);
    entry_req   = doEntry;
    entry_class = eCls;
    exit_req    = doExit;
    exit_class  = xCls;
    @(negedge clk);
    entry_req = 1'b0;
    exit_req  = 1'b0;
  endtask

  function automatic logic [31:0] parkedOf(input int c);
    return 32'(parked_cnt[c*CW +: CW]);
  endfunction

  function automatic logic [31:0] freeOf(input int c);
    return 32'(free_cnt[c*CW +: CW]);
  endfunction

  initial begin
    checkCount  = 0;
    failCount   = 0;
    reset       = 1'b0;
    entry_req   = 1'b0;
    exit_req    = 1'b0;
    entry_class = '0;
    exit_class  = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rstParked0", parkedOf(0), 0);
    checkOutput("rstFree0", freeOf(0), 500);
    checkOutput("rstFree1", freeOf(1), 200);
    checkOutput("rstShared", 32'(shared_used), 0);
    checkOutput("rstAvail", 32'(space_avail), 3);
    checkOutput("rstAcks", 32'({entry_ack, entry_nack, exit_ack, exit_nack}), 0);
    reset = 1'b1;

    // Single class-0 entry
    applyStimulus(1'b1, 2'(CLASS_UNI), 1'b0, 2'd0);
    checkOutput("e0Ack", 32'(entry_ack), 1);
    checkOutput("e0Nack", 32'(entry_nack), 0);
    checkOutput("e0Parked0", parkedOf(0), 1);
    checkOutput("e0Free0", freeOf(0), 499);
    checkOutput("e0Parked1", parkedOf(1), 0);
    checkOutput("e0Shared", 32'(shared_used), 0);
    @(negedge clk);
    checkOutput("e0AckPulse", 32'(entry_ack), 0);

    // Level held five cycles counts once
    ackCount = 0;
    @(negedge clk);
    entry_req   = 1'b1;
    entry_class = 2'(CLASS_PUBLIC);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      ackCount += int'(entry_ack);
    end
    entry_req = 1'b0;
    @(negedge clk);
    ackCount += int'(entry_ack);
    checkOutput("holdAcks", 32'(ackCount), 1);
    checkOutput("holdParked1", parkedOf(1), 1);

    // Request held high across reset release is not an event
    entry_req = 1'b1;
    reset     = 1'b0;
    repeat (2) @(negedge clk);
    reset    = 1'b1;
    ackCount = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      ackCount += int'(entry_ack) + int'(entry_nack);
    end
    entry_req = 1'b0;
    checkOutput("rstHoldResp", 32'(ackCount), 0);
    checkOutput("rstHoldParked0", parkedOf(0), 0);
    checkOutput("rstHoldParked1", parkedOf(1), 0);

    // Fill class 1: 200 private plus the whole shared pool
    ackCount = 0;
    for (int k = 0; k < 216; k++) begin
      applyStimulus(1'b1, 2'(CLASS_PUBLIC), 1'b0, 2'd0);
      ackCount += int'(entry_ack);
    end
    checkOutput("fillAcks", 32'(ackCount), 216);
    checkOutput("fillParked1", parkedOf(1), 216);
    checkOutput("fillFree1", freeOf(1), 0);
    checkOutput("fillShared", 32'(shared_used), 16);
    checkOutput("fillAvail", 32'(space_avail), 1);

    // 217th class-1 entry is refused
    applyStimulus(1'b1, 2'(CLASS_PUBLIC), 1'b0, 2'd0);
    checkOutput("overNack", 32'(entry_nack), 1);
    checkOutput("overAck", 32'(entry_ack), 0);
    checkOutput("overParked1", parkedOf(1), 216);
    checkOutput("overShared", 32'(shared_used), 16);

    // Class 0 still has private room
    applyStimulus(1'b1, 2'(CLASS_UNI), 1'b0, 2'd0);
    checkOutput("uniAck", 32'(entry_ack), 1);
    checkOutput("uniParked0", parkedOf(0), 1);
    checkOutput("uniShared", 32'(shared_used), 16);

    // Class-1 exit releases a borrowed space first
    applyStimulus(1'b0, 2'd0, 1'b1, 2'(CLASS_PUBLIC));
    checkOutput("x1Ack", 32'(exit_ack), 1);
    checkOutput("x1Shared", 32'(shared_used), 15);
    checkOutput("x1Free1", freeOf(1), 0);
    checkOutput("x1Parked1", parkedOf(1), 215);
    checkOutput("x1Avail", 32'(space_avail), 3);

    // Back to full, then simultaneous entry and exit on class 1
    applyStimulus(1'b1, 2'(CLASS_PUBLIC), 1'b0, 2'd0);
    checkOutput("refillShared", 32'(shared_used), 16);
    applyStimulus(1'b1, 2'(CLASS_PUBLIC), 1'b1, 2'(CLASS_PUBLIC));
    checkOutput("simEntryAck", 32'(entry_ack), 1);
    checkOutput("simExitAck", 32'(exit_ack), 1);
    checkOutput("simParked1", parkedOf(1), 216);
    checkOutput("simShared", 32'(shared_used), 16);

    // Drain class 0, then exit from an empty class
    applyStimulus(1'b0, 2'd0, 1'b1, 2'(CLASS_UNI));
    checkOutput("x0Ack", 32'(exit_ack), 1);
    checkOutput("x0Parked0", parkedOf(0), 0);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'(CLASS_UNI));
    checkOutput("x0EmptyNack", 32'(exit_nack), 1);
    checkOutput("x0EmptyAck", 32'(exit_ack), 0);

    // Invalid class indices
    applyStimulus(1'b1, 2'd3, 1'b0, 2'd0);
    checkOutput("badEntryNack", 32'(entry_nack), 1);
    checkOutput("badEntryParked0", parkedOf(0), 0);
    applyStimulus(1'b0, 2'd0, 1'b1, 2'd2);
    checkOutput("badExitNack", 32'(exit_nack), 1);
    checkOutput("badExitShared", 32'(shared_used), 16);

    // Reset asserted during a burst cuts the ack pulse and clears all counts
    @(negedge clk);
    entry_req   = 1'b1;
    entry_class = 2'(CLASS_UNI);
    @(posedge clk);
    #1;
    checkOutput("burstAck", 32'(entry_ack), 1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("burstAckCut", 32'(entry_ack), 0);
    checkOutput("burstParked0", parkedOf(0), 0);
    checkOutput("burstParked1", parkedOf(1), 0);
    checkOutput("burstShared", 32'(shared_used), 0);
    checkOutput("burstFree1", freeOf(1), 200);
    ackCount = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      entry_req = ~entry_req;
      exit_req  = ~exit_req;
      ackCount += int'(entry_ack) + int'(entry_nack) + int'(exit_ack) + int'(exit_nack);
    end
    checkOutput("burstNoResp", 32'(ackCount), 0);
    entry_req = 1'b0;
    exit_req  = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("postRstParked0", parkedOf(0), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
